// File: rtl/ucie_ctl_sb_pkg.sv
// Shared types and helpers for the UCIe sideband control arbiters.
package ucie_ctl_sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  localparam int MSG_W_DEFAULT = 128;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ucie_ctl_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NREQ-1 to 0.
module ucie_ctl_rr_pick
  import ucie_ctl_sb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [NREQ-1:0] rot;
  logic [IDX_W:0]  sum;

  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
        idx   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_tx_arb.sv
// Round-robin arbiter/sequencer sharing the sideband TX FSM among NREQ sources.
//   state     | meaning
//   IDLE      | waiting for any request; grant and latch message on the edge
//   LAUNCH    | valid high, waiting for busy to rise (bounded by TIMEOUT)
//   WAIT_DONE | FSM sending; valid held until busy falls (no time bound)
//   GAP       | valid and grant low for one cycle before the next launch
module ucie_ctl_sb_tx_arb
  import ucie_ctl_sb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MSG_W   = MSG_W_DEFAULT,
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*MSG_W-1:0] i_req_msg,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_ack,
  output logic [NREQ-1:0]       o_err,
  output logic                  o_valid_lp_sb,
  output logic [MSG_W-1:0]      o_sb_msg,
  input  logic                  i_pl_sb_busy,
  output logic                  o_arb_busy
);

  localparam int              IDX_W   = clog2_min1(NREQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [TO_W-1:0]  cnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [MSG_W-1:0] msg_sel;
  logic [IDX_W-1:0] next_ptr;

  ucie_ctl_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (i_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    msg_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == IDX_W'(k)) msg_sel = i_req_msg[k*MSG_W +: MSG_W];
    end
  end

  assign next_ptr = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      win_idx       <= '0;
      cnt           <= '0;
      o_gnt         <= '0;
      o_ack         <= '0;
      o_err         <= '0;
      o_valid_lp_sb <= 1'b0;
      o_sb_msg      <= '0;
      o_arb_busy    <= 1'b0;
    end else begin
      o_ack <= '0;
      o_err <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state         <= ST_LAUNCH;
            win_idx       <= pick_idx;
            o_sb_msg      <= msg_sel;
            o_gnt         <= ONE_HOT << pick_idx;
            o_valid_lp_sb <= 1'b1;
            o_arb_busy    <= 1'b1;
            cnt           <= '0;
          end
        end
        ST_LAUNCH: begin
          // A busy rise on the same edge as the timeout still wins.
          if (i_pl_sb_busy) begin
            state <= ST_WAIT_DONE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state         <= ST_GAP;
            o_err         <= o_gnt;
            o_gnt         <= '0;
            o_valid_lp_sb <= 1'b0;
            rr_ptr        <= next_ptr;
            cnt           <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!i_pl_sb_busy) begin
            state         <= ST_GAP;
            o_ack         <= o_gnt;
            o_gnt         <= '0;
            o_valid_lp_sb <= 1'b0;
            rr_ptr        <= next_ptr;
          end
        end
        ST_GAP: begin
          state      <= ST_IDLE;
          o_arb_busy <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          o_gnt         <= '0;
          o_valid_lp_sb <= 1'b0;
          o_arb_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arb.sv
// Self-checking bench for ucie_ctl_sb_tx_arb: vector table, hand sequences and
// randomized transactions against a transaction-level round-robin model.
module tb_ucie_ctl_sb_tx_arb;

  localparam int NREQ    = 3;
  localparam int MSG_W   = 128;
  localparam int TIMEOUT = 5;
  localparam int TO_W    = 8;

  logic                  i_clk;
  logic                  i_rst;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*MSG_W-1:0] i_req_msg;
  logic [NREQ-1:0]       o_gnt;
  logic [NREQ-1:0]       o_ack;
  logic [NREQ-1:0]       o_err;
  logic                  o_valid_lp_sb;
  logic [MSG_W-1:0]      o_sb_msg;
  logic                  i_pl_sb_busy;
  logic                  o_arb_busy;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  ucie_ctl_sb_tx_arb #(
    .NREQ    (NREQ),
    .MSG_W   (MSG_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req         (i_req),
    .i_req_msg     (i_req_msg),
    .o_gnt         (o_gnt),
    .o_ack         (o_ack),
    .o_err         (o_err),
    .o_valid_lp_sb (o_valid_lp_sb),
    .o_sb_msg      (o_sb_msg),
    .i_pl_sb_busy  (i_pl_sb_busy),
    .o_arb_busy    (o_arb_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NREQ-1:0] req;
    int              d;
    int              h;
    logic [NREQ-1:0] gnt;
    bit              ack;
    int              vh;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] oh);
    for (int k = 0; k < NREQ; k++)
      if (oh[k]) return k;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] idx2oh(input int idx);
    logic [NREQ-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  function automatic logic [MSG_W-1:0] msg_of(input int idx);
    return i_req_msg[idx*MSG_W +: MSG_W];
  endfunction

  task automatic scramble_msgs();
    for (int k = 0; k < NREQ; k++)
      i_req_msg[k*MSG_W +: MSG_W] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at the first negedge where valid is observed high. Plays the TX FSM:
  // busy set at step d, cleared at step d+h; d >= TIMEOUT means busy never rises.
  // Returns at the negedge after GAP, with the arbiter back in IDLE.
  task automatic serve(input logic [NREQ-1:0] eg, input logic [MSG_W-1:0] em,
                       input int d, input int h, input bit eack, input int evh,
                       input bit drop);
    int  vh;
    int  j;
    bit  seen;
    bit  gnt_bad;
    bit  tmo;
    tmo = (d >= TIMEOUT);
    chk("grant", o_gnt, eg);
    chk("msg_at_grant", o_sb_msg, em);
    chk("arb_busy_launch", o_arb_busy, 1);
    if (drop) i_req = '0;
    scramble_msgs();
    vh = 1; j = 0; seen = 0; gnt_bad = 0;
    while (!seen && j < d + h + TIMEOUT + 10) begin
      if (!tmo && j == d) i_pl_sb_busy = 1'b1;
      if (!tmo && j == d + h) i_pl_sb_busy = 1'b0;
      @(negedge i_clk);
      j++;
      if (o_ack != '0 || o_err != '0) seen = 1;
      else begin
        if (o_valid_lp_sb) vh++;
        if (o_gnt != eg) gnt_bad = 1;
      end
    end
    i_pl_sb_busy = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL pulse_wait: no ack/err within %0d cycles", j);
      return;
    end
    chk("valid_high_cycles", vh, evh);
    chk("ack", o_ack, eack ? eg : '0);
    chk("err", o_err, eack ? '0 : eg);
    chk("valid_low_at_done", o_valid_lp_sb, 0);
    chk("gnt_low_in_gap", o_gnt, 0);
    chk("arb_busy_in_gap", o_arb_busy, 1);
    chk("msg_stable", o_sb_msg, em);
    chk("gnt_held", gnt_bad, 0);
    @(negedge i_clk);
    chk("pulse_one_cycle", {o_ack, o_err}, 0);
    chk("valid_low_gap", o_valid_lp_sb, 0);
    chk("arb_idle_after_gap", o_arb_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0]  r;
    logic [MSG_W-1:0] em;
    int               w;
    int               d;
    int               h;
    bit               tmo;

    vecs[0] = '{3'b001, 2, 10,   3'b001, 1, 13};
    vecs[1] = '{3'b001, 0, 1,    3'b001, 1, 2};
    vecs[2] = '{3'b101, 0, 1,    3'b100, 1, 2};
    vecs[3] = '{3'b110, 5, 0,    3'b010, 0, 5};
    vecs[4] = '{3'b011, 4, 1,    3'b001, 1, 6};
    vecs[5] = '{3'b111, 0, 3,    3'b010, 1, 4};
    vecs[6] = '{3'b011, 1, 1000, 3'b001, 1, 1002};
    vecs[7] = '{3'b100, 7, 0,    3'b100, 0, 5};

    i_rst = 1'b0;
    i_req = '0;
    i_pl_sb_busy = 1'b0;
    scramble_msgs();
    repeat (2) @(negedge i_clk);
    chk("rst_valid", o_valid_lp_sb, 0);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_ack_err", {o_ack, o_err}, 0);
    chk("rst_msg", o_sb_msg, 0);
    chk("rst_arb_busy", o_arb_busy, 0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Vector table, starting from rr_ptr = 0.
    for (int v = 0; v < 8; v++) begin
      scramble_msgs();
      i_req = vecs[v].req;
      em = msg_of(oh2idx(vecs[v].gnt));
      @(negedge i_clk);
      chk("latency_valid", o_valid_lp_sb, 1);
      serve(vecs[v].gnt, em, vecs[v].d, vecs[v].h, vecs[v].ack, vecs[v].vh, 1'b1);
    end
    exp_ptr = 0;

    // Contention: all requests held, expect round-robin 0,1,2,0.
    i_req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      w  = rr_winner(3'b111, exp_ptr);
      em = msg_of(w);
      @(negedge i_clk);
      chk("contention_latency", o_valid_lp_sb, 1);
      serve(idx2oh(w), em, 0, 1, 1'b1, 2, 1'b0);
      exp_ptr = (w + 1) % NREQ;
      if (n == 3) i_req = '0;
    end
    @(negedge i_clk);
    chk("idle_no_req", o_valid_lp_sb, 0);

    // Randomized transactions against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d = $urandom_range(0, TIMEOUT + 1);
      h = $urandom_range(1, 6);
      tmo = (d >= TIMEOUT);
      w = rr_winner(r, exp_ptr);
      scramble_msgs();
      i_req = r;
      em = msg_of(w);
      @(negedge i_clk);
      chk("rand_latency", o_valid_lp_sb, 1);
      serve(idx2oh(w), em, d, h, !tmo, tmo ? TIMEOUT : d + h + 1, 1'b1);
      exp_ptr = (w + 1) % NREQ;
    end

    // Reset in the middle of a send.
    i_req = 3'b001;
    @(negedge i_clk);
    chk("pre_reset_valid", o_valid_lp_sb, 1);
    i_req = '0;
    i_pl_sb_busy = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("pre_reset_sending", o_valid_lp_sb, 1);
    #2 i_rst = 1'b0;
    #1;
    chk("midrst_valid", o_valid_lp_sb, 0);
    chk("midrst_gnt", o_gnt, 0);
    chk("midrst_ack_err", {o_ack, o_err}, 0);
    chk("midrst_msg", o_sb_msg, 0);
    chk("midrst_arb_busy", o_arb_busy, 0);
    i_pl_sb_busy = 1'b0;
    i_req = 3'b010;
    repeat (2) @(negedge i_clk);
    chk("midrst_no_pulse", {o_ack, o_err, o_valid_lp_sb}, 0);
    exp_ptr = 0;
    i_rst = 1'b1;
    w  = rr_winner(3'b010, exp_ptr);
    em = msg_of(w);
    @(negedge i_clk);
    chk("post_reset_latency", o_valid_lp_sb, 1);
    serve(idx2oh(w), em, 0, 2, 1'b1, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
